// File: rtl/ex_stage.sv
// ex_stage: pipeline execute stage with EX/MEM and WB operand forwarding,
// a single-cycle ALU and an optional 32-iteration shift-add multiplier.
// Optional feature macro: EX_MUL_EN (multiplier FSM and FUNCT 0x18 support).
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   REG_WRITE, ALU_SRC, ALU_OP, FUNCT  ID/EX control fields
//   DATA1, DATA2, IMM, RS, RT, RD      ID/EX operand and register fields
//   WB_REG_WRITE, WB_RD, WB_DATA       write-back forwarding source
//   REG_WRITE_O, RESULT_O, RD_O        registered EX/MEM outputs
//   STALL_O                            combinational hold request to upstream
module ex_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        REG_WRITE,
    input  logic        ALU_SRC,
    input  logic [1:0]  ALU_OP,
    input  logic [5:0]  FUNCT,
    input  logic [31:0] DATA1,
    input  logic [31:0] DATA2,
    input  logic [31:0] IMM,
    input  logic [4:0]  RS,
    input  logic [4:0]  RT,
    input  logic [4:0]  RD,
    input  logic        WB_REG_WRITE,
    input  logic [4:0]  WB_RD,
    input  logic [31:0] WB_DATA,
    output logic        REG_WRITE_O,
    output logic [31:0] RESULT_O,
    output logic [4:0]  RD_O,
    output logic        STALL_O
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned RLEN = 5;

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;

    // Operand forwarding: EX/MEM beats WB beats register file; r0 never forwarded.
    always_comb begin
        op_a = DATA1;
        if (REG_WRITE_O && (RD_O != '0) && (RD_O == RS))
            op_a = RESULT_O;
        else if (WB_REG_WRITE && (WB_RD != '0) && (WB_RD == RS))
            op_a = WB_DATA;

        fwd_b = DATA2;
        if (REG_WRITE_O && (RD_O != '0) && (RD_O == RT))
            fwd_b = RESULT_O;
        else if (WB_REG_WRITE && (WB_RD != '0) && (WB_RD == RT))
            fwd_b = WB_DATA;

        op_b = ALU_SRC ? IMM : fwd_b;
    end

    // Single-cycle ALU; mult (0x18) is handled by the FSM, so it decodes as 0 here.
    always_comb begin
        alu_res = '0;
        case (ALU_OP)
            2'b00: alu_res = op_a + op_b;
            2'b01: alu_res = op_a - op_b;
            2'b10: begin
                case (FUNCT)
                    6'h20:   alu_res = op_a + op_b;
                    6'h22:   alu_res = op_a - op_b;
                    6'h24:   alu_res = op_a & op_b;
                    6'h25:   alu_res = op_a | op_b;
                    6'h2A:   alu_res = XLEN'($signed(op_a) < $signed(op_b));
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

`ifdef EX_MUL_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    mul_state_t      state;
    logic [RLEN-1:0] cnt;
    logic [XLEN-1:0] mul_a;
    logic [XLEN-1:0] mul_b;
    logic [XLEN-1:0] acc;
    logic [RLEN-1:0] mul_rd;
    logic            mul_we;
    logic            is_mult;

    assign is_mult = (ALU_OP == 2'b10) && (FUNCT == 6'h18);

    // Hold upstream from first presentation of a mult through the last iteration.
    always_comb begin
        STALL_O = 1'b0;
        if (!rst_i)
            STALL_O = ((state == IDLE) && is_mult) || (state == BUSY);
    end

    // EX/MEM register plus multiplier FSM; bubbles carry REG_WRITE_O=0 so they never forward.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            REG_WRITE_O <= 1'b0;
            RESULT_O    <= '0;
            RD_O        <= '0;
            state       <= IDLE;
            cnt         <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            acc         <= '0;
            mul_rd      <= '0;
            mul_we      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mult) begin
                        mul_a       <= op_a;
                        mul_b       <= op_b;
                        acc         <= '0;
                        cnt         <= '0;
                        mul_rd      <= RD;
                        mul_we      <= REG_WRITE;
                        state       <= BUSY;
                        REG_WRITE_O <= 1'b0;
                        RESULT_O    <= '0;
                        RD_O        <= '0;
                    end else begin
                        REG_WRITE_O <= REG_WRITE;
                        RESULT_O    <= alu_res;
                        RD_O        <= RD;
                    end
                end
                BUSY: begin
                    if (mul_b[0])
                        acc <= acc + mul_a;
                    mul_a       <= mul_a << 1;
                    mul_b       <= mul_b >> 1;
                    cnt         <= RLEN'(cnt + RLEN'(1));
                    REG_WRITE_O <= 1'b0;
                    RESULT_O    <= '0;
                    RD_O        <= '0;
                    if (cnt == RLEN'(31))
                        state <= DONE;
                end
                DONE: begin
                    REG_WRITE_O <= mul_we;
                    RESULT_O    <= acc;
                    RD_O        <= mul_rd;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign STALL_O = 1'b0;

    // EX/MEM register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            REG_WRITE_O <= 1'b0;
            RESULT_O    <= '0;
            RD_O        <= '0;
        end else begin
            REG_WRITE_O <= REG_WRITE;
            RESULT_O    <= alu_res;
            RD_O        <= RD;
        end
    end
`endif

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
- REQ-001 SHALL provide: clk_i  in  1  single clock; all state updates on rising edge.
- REQ-002 SHALL provide: rst_i  in  1  reset, synchronous, active-high.
- REQ-003 SHALL provide: REG_WRITE, ALU_SRC  in  1 each; ALU_OP  in  2; FUNCT  in  6. These are the ID/EX control fields.
- REQ-004 SHALL provide: DATA1, DATA2, IMM  in  32 each; RS, RT, RD  in  5 each. These are the ID/EX operand and register fields.
- REQ-005 SHALL provide: WB_REG_WRITE  in  1; WB_RD  in  5; WB_DATA  in  32. These carry the write-back forwarding source.
- REQ-006 SHALL provide: REG_WRITE_O  out  1; RESULT_O  out  32; RD_O  out  5. These are the registered EX/MEM outputs.
- REQ-007 SHALL provide: STALL_O  out  1. When high, upstream holds all ID/EX inputs stable.

Function
- REQ-008 SHALL forward operand A (source RS) and operand B (source RT) with this priority: EX/MEM (REG_WRITE_O, RD_O, RESULT_O) first, then WB (WB_REG_WRITE, WB_RD, WB_DATA), then DATA1/DATA2.
- REQ-009 SHALL never forward when the matching RD is 0.
- REQ-010 SHALL use IMM in place of forwarded operand B when ALU_SRC=1.
- REQ-011 SHALL decode ALU_OP: 00 add; 01 sub; 10 R-type by FUNCT; 11 result 0.
- REQ-012 SHALL decode R-type FUNCT: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt (result 0/1), 0x18 mult (REQ-016). Any other FUNCT gives result 0.
- REQ-013 SHALL wrap add/sub modulo 2^32, with no overflow flag.
- REQ-014 SHALL give single-cycle ops 1-cycle latency: inputs at edge N appear on REG_WRITE_O/RESULT_O/RD_O after edge N.
- REQ-015 SHALL implement the multiplier FSM with states IDLE, BUSY, DONE and a 5-bit iteration counter.
- REQ-016 SHALL perform mult as an unsigned shift-add of operand A x operand B, with RESULT_O = low 32 bits.
- REQ-017 SHALL behave as follows in IDLE with mult at input: STALL_O=1 combinationally; at the next edge, capture operands, clear the counter, go to BUSY, and load a bubble (REG_WRITE_O=0, RD_O=0, RESULT_O=0).
- REQ-018 SHALL behave as follows in BUSY: STALL_O=1; do one shift-add per edge; output a bubble each edge; after the 32nd iteration (counter=31), go to DONE.
- REQ-019 SHALL behave as follows in DONE: STALL_O=0; at the next edge, register the product with REG_WRITE and RD, then go to IDLE.
- REQ-020 SHALL give mult 33 STALL_O-high cycles and a result valid 34 edges after first presentation.
- REQ-021 SHALL ignore changes to DATA*/WB_* after capture; the captured operands are authoritative.
- REQ-022 SHALL use the pre-mult EX/MEM contents for forwarding into a mult presented in IDLE, and SHALL not forward from bubbles.
- REQ-023 SHALL treat back-to-back mults (next mult present in DONE cycle) as follows: DONE->IDLE, then the next mult begins a fresh sequence.

Reset
- REQ-024 SHALL, while rst_i=1 at an edge, clear REG_WRITE_O=0, RESULT_O=0, RD_O=0, the state to IDLE, the counter to 0, and captured operands to 0.
- REQ-025 SHALL force STALL_O=0 while rst_i=1.
- REQ-026 SHALL abort any in-flight mult on reset mid-BUSY without producing a result; a mult still at input after reset restarts from IDLE.

Configuration
- REQ-027 SHALL compile in the FSM, counter and FUNCT 0x18 support when EX_MUL_EN is defined.
- REQ-028 SHALL, without EX_MUL_EN, handle FUNCT 0x18 as unknown (result 0, 1-cycle latency), tie STALL_O to 0, and instantiate no multiplier state.

Verification
- REQ-029 SHALL cover: add, DATA1=5, DATA2=7, RD=3, REG_WRITE=1 -> next edge RESULT_O=12, RD_O=3, REG_WRITE_O=1.
- REQ-030 SHALL cover: sub 3-5 -> RESULT_O=0xFFFFFFFE; slt -1 vs 1 -> RESULT_O=1.
- REQ-031 SHALL cover: RD_O=4 holding 9, WB_RD=4 holding 2, next op RS=4 add IMM=1 (ALU_SRC=1) -> RESULT_O=10 (EX/MEM priority); RS=0 with matches -> DATA1 used.
- REQ-032 SHALL cover: EX_MUL_EN, mult 0x10000 x 0x10003 -> STALL_O high 33 cycles, bubbles meanwhile, then RESULT_O=0x00030000.
- REQ-033 SHALL cover: reset asserted at BUSY cycle 10 -> all outputs 0, STALL_O=0, state IDLE; re-presented mult completes correctly.
- REQ-034 SHALL cover: without EX_MUL_EN, FUNCT 0x18 -> STALL_O=0, RESULT_O=0 after 1 edge.
